// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler: FSM state encoding and
// the op code values that clients and benches use when driving the shared ALU.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // The scheduler never decodes these; they document the external ALU's op map.
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] SLL = 3'd2;
  localparam logic [2:0] SRL = 3'd3;
  localparam logic [2:0] AND = 3'd4;
  localparam logic [2:0] OR  = 3'd5;
  localparam logic [2:0] XOR = 3'd6;
  localparam logic [2:0] EQL = 3'd7;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or
// above ptr, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int  idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational 8-bit ALU among NUM_REQ
// requesters; results return with the requester ID on a valid/ready channel.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_a_i,
  input  logic [NUM_REQ*8-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0] req_op_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           alu_a_o,
  output logic [7:0]           alu_b_o,
  output logic [2:0]           alu_op_o,
  input  logic [7:0]           alu_res_i,
  output logic                 rsp_valid_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [7:0]           rsp_data_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: a request transfers in the cycle req_valid_i[i] & req_ready_o[i];
  // a response transfers in the cycle rsp_valid_o & rsp_ready_i. Ready never
  // depends on a request that is not valid, and rsp fields hold while unaccepted.

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign next_ptr    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign req_ready_o = (state == IDLE && !reset) ? grant : '0;
  assign dbg_state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_op_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_a_o  <= req_a_i[grant_idx*8 +: 8];
            alu_b_o  <= req_b_i[grant_idx*8 +: 8];
            alu_op_o <= req_op_i[grant_idx*3 +: 3];
            rsp_id_o <= grant_idx;
            rr_ptr   <= next_ptr;
            busy_o   <= 1'b1;
            state    <= ISSUE;
          end
        end
        // Operands have been stable for a full cycle, so the ALU output is settled.
        ISSUE: begin
          rsp_data_o  <= alu_res_i;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one combinational 8-bit ALU among NUM_REQ requesters. It accepts one request per transaction, drives the shared ALU's operand and op inputs from registers, and captures the result. It returns the result with the requester's ID over a valid/ready response channel. It sits between the client blocks and the single ALU instance, so the ALU is never driven by more than one client.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ID_W, $clog2(NUM_REQ): requester ID width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_a_i  in  NUM_REQ×8  per-requester operand A (packed, requester 0 in LSBs)
- req_b_i  in  NUM_REQ×8  per-requester operand B
- req_op_i  in  NUM_REQ×3  per-requester 3-bit op code
- req_ready_o  out  NUM_REQ  one-hot accept strobe
- alu_a_o  out  8  operand A to shared ALU
- alu_b_o  out  8  operand B to shared ALU
- alu_op_o  out  3  op to shared ALU
- alu_res_i  in  8  shared ALU result (combinational from alu_*_o)
- rsp_valid_o  out  1  response valid
- rsp_id_o  out  ID_W  requester index of response
- rsp_data_o  out  8  ALU result
- rsp_ready_i  in  1  response consumer ready
- busy_o  out  1  high in ISSUE or RESP

## Operation
- FSM states are IDLE, ISSUE and RESP. Reset state is IDLE.
- IDLE:
  - grant = first set bit of req_valid_i, searching from rr_ptr upward with wrap-around.
  - req_ready_o = grant (combinational). It is all-zero if no valid, and all-zero while reset is high.
  - If any request is granted, register its a/b/op into alu_a_o/alu_b_o/alu_op_o and its index into rsp_id_o.
  - Then set rr_ptr = granted index + 1 (mod NUM_REQ) and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Operand registers are stable; capture alu_res_i into rsp_data_o.
  - Go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_id_o and rsp_data_o are held stable.
  - When rsp_ready_i = 1, return to IDLE.
  - No new request is accepted in RESP; the next grant happens in IDLE the following cycle.
- Op codes pass through unmodified. Any 3-bit value is accepted, and the scheduler never interprets op or result.
- Fairness:
  - rr_ptr advances only on a grant.
  - A requester holding req_valid_i high is served within NUM_REQ transactions.
- Requesters keep request fields stable while valid and not accepted. Dropping valid before acceptance is legal; the request is simply not granted.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - alu_a_o = 0, alu_b_o = 0, alu_op_o = 0.
  - rsp_valid_o = 0, rsp_id_o = 0, rsp_data_o = 0.
  - busy_o = 0, req_ready_o = 0.
- Accept in cycle T (req_valid & req_ready). Then:
  - alu_*_o are valid from T+1.
  - rsp_valid_o = 1 from T+2.
- With rsp_ready_i tied high, the minimum issue interval is 3 cycles (IDLE, ISSUE, RESP), giving a throughput of 1 result per 3 cycles.
- Response is held indefinitely under rsp_ready_i = 0, with no data or ID change.
- Reset mid-operation (ISSUE or RESP): the FSM returns to IDLE asynchronously, all outputs take their reset values, and the in-flight transaction is dropped with no response.
- Simultaneous requests from all requesters: exactly one bit of req_ready_o is set per grant.
- A requester reasserting valid in the same cycle rr_ptr passes it waits for its turn per the rr order.

## Structure
- Shared package alu_sched_pkg:
  - state enum (IDLE, ISSUE, RESP).
  - op code constants ADD=0, SUB=1, SLL=2, SRL=3, AND=4, OR=5, XOR=6, EQL=7 (for benches and clients).
- One natural sub-module: rr_arbiter (NUM_REQ). Its ports are req, ptr, one-hot grant and encoded grant index, and it is purely combinational.

## Test plan
- Single request: requester 2 issues a=8'h05, b=8'h03, op=0 with an external adder ALU. Required: ready[2] in T, rsp_valid at T+2, rsp_id=2, rsp_data=8'h08.
- All 4 requesters hold valid continuously with rsp_ready=1. Required: grant order is 0,1,2,3,0 and grants are 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. Required: rsp_valid, id and data are stable, and req_ready stays 0 throughout.
- Wrap: after requester 3 is served, requesters 0 and 3 both request. Required: requester 0 is granted first.
- Reset asserted in ISSUE. Required: all outputs go to reset values immediately, and no rsp_valid occurs. After release, the pending request is granted from rr_ptr=0.
- Op passthrough: op=7, a=b=8'hAA with an external ALU. Required: alu_op_o=7 at T+1 and rsp_data=8'h01.
